cpu64_obi_arbiter: RTL and testbench
====================================

Name: cpu64_obi_arbiter

Overview:
N-master to 1-slave OBI arbiter with outstanding-transaction tracking. It merges several core-side OBI ports, for example the instruction fetch and the cache-stack miss port, onto one external memory port. Arbitration is round-robin, and the winner is locked while the slave stalls. Responses are routed back in order through a FIFO of master indices, so up to MAX_OUTSTANDING transactions can be in flight.

Parameters:
NUM_MASTERS, 2, number of OBI master channels (>=1).
ADDR_W, 39, address width per channel.
DATA_W, 64, data width; byte-enable width BE_W = DATA_W/8.
MAX_OUTSTANDING, 4, depth of the response-routing FIFO (>=1, power of two).

Ports:
clk_i  in  1  clock; all state updates on its rising edge.
rst_ni  in  1  asynchronous active-low reset.
m_req_i  in  NUM_MASTERS  per-master request.
m_gnt_o  out  NUM_MASTERS  per-master grant.
m_addr_i  in  NUM_MASTERS*ADDR_W  packed addresses; master k occupies bits [k*ADDR_W +: ADDR_W].
m_we_i  in  NUM_MASTERS  per-master write enable.
m_be_i  in  NUM_MASTERS*BE_W  packed byte enables.
m_wdata_i  in  NUM_MASTERS*DATA_W  packed write data.
m_rvalid_o  out  NUM_MASTERS  per-master response valid; one-hot or zero.
m_rdata_o  out  DATA_W  response data, broadcast to all masters.
s_req_o  out  1  slave request.
s_gnt_i  in  1  slave grant.
s_addr_o  out  ADDR_W  slave address.
s_we_o  out  1  slave write enable.
s_be_o  out  BE_W  slave byte enables.
s_wdata_o  out  DATA_W  slave write data.
s_rvalid_i  in  1  slave response valid.
s_rdata_i  in  DATA_W  slave response data.
outstanding_o  out  clog2(MAX_OUTSTANDING)+1  number of transactions in flight.
err_o  out  1  sticky flag: a response arrived with nothing outstanding.

Behaviour:
- Reset (async, rst_ni=0): FIFO empty, outstanding_o=0, rr_ptr=0, lock cleared, err_o=0. With all m_req_i=0, every combinational output is 0.
- Registered state:
  - rr_ptr: index of the highest-priority master.
  - lock_vld, lock_idx: winner held over a stalled request.
  - FIFO of master indices, depth MAX_OUTSTANDING, with count, rd_ptr and wr_ptr.
  - err_o.
- Winner selection (combinational):
  - if lock_vld, winner = lock_idx;
  - otherwise, winner = first k with m_req_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
- full = (count == MAX_OUTSTANDING).
- s_req_o = (some m_req_i asserted or lock_vld) AND NOT full.
- s_addr_o, s_we_o, s_be_o and s_wdata_o are muxed from the winner. When s_req_o=0 they are don't-care; drive 0.
- m_gnt_o[winner] = s_req_o & s_gnt_i. All other grant bits are 0. Zero-cycle grant path, no added latency.
- Handshake hs = s_req_o & s_gnt_i:
  - push winner index into the FIFO;
  - rr_ptr <= (winner+1) mod NUM_MASTERS;
  - lock_vld <= 0.
- Stall (s_req_o=1, s_gnt_i=0): lock_vld <= 1 and lock_idx <= winner. A competing higher-priority request cannot change the slave-side payload until hs (OBI stability rule).
- While full, s_req_o=0. An existing lock is retained and no new lock forms. There is no push/pop bypass: a pop in the same cycle frees a slot only from the next cycle.
- Response path:
  - if s_rvalid_i and count>0: m_rvalid_o[FIFO head]=1 in the same cycle, m_rdata_o = s_rdata_i (combinational), then pop.
  - if s_rvalid_i and count==0: no m_rvalid_o bit is asserted, the response is dropped, and err_o <= 1 (sticky until reset).
- Simultaneous push and pop: count is unchanged; both pointers advance (wrap modulo MAX_OUTSTANDING).
- outstanding_o = count (registered).
- Responses return strictly in grant order; masters receive them in the order their requests were granted.
- NUM_MASTERS=1: rr_ptr is held at 0; the index width is a minimum of 1 bit.
- Reset asserted mid-transaction: all state clears immediately. In-flight responses arriving after reset set err_o. This is intended; reset the slave together with the arbiter.

Test Plan:
1. Master 0 read to 0x1000, slave grants at once, rvalid 2 cycles later with 0xDEADBEEF_CAFEF00D -> m_gnt_o=01 for 1 cycle; m_rvalid_o=01 with that rdata; outstanding_o goes 1 then 0.
2. Masters 0 and 1 request continuously, s_gnt_i=1, responses queued -> grant order 0,1,0,1; m_rvalid_o order 01,10,01,10.
3. Master 1 requests at 0x2000 with s_gnt_i=0 for 3 cycles; master 0 raises req in cycle 2 -> s_addr_o stays 0x2000 and the winner stays 1 until grant; master 0 is granted next.
4. MAX_OUTSTANDING=4: 4 grants with no rvalid -> s_req_o=0 and outstanding_o=4; one rvalid -> s_req_o=1 the following cycle.
5. s_rvalid_i pulse with outstanding_o=0 -> m_rvalid_o=00, err_o=1 and held; clears only on rst_ni=0.
6. rst_ni=0 with 2 transactions outstanding and a lock active -> outstanding_o=0, s_req_o=0 (no requests), lock cleared, rr_ptr=0.

Source files
------------

// File: rtl/cpu64_obi_arbiter.sv
// N-master to 1-slave OBI arbiter: round-robin with stall lock, in-order response routing.
module cpu64_obi_arbiter #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_W          = 39,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_MASTERS-1:0]          m_req_i,
  output logic [NUM_MASTERS-1:0]          m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic                            s_req_o,
  input  logic                            s_gnt_i,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic                            s_we_o,
  output logic [DATA_W/8-1:0]             s_be_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  input  logic                            s_rvalid_i,
  input  logic [DATA_W-1:0]               s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                            err_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic             lock_vld;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head;
  logic             full;
  logic             hs;
  logic             pop;
  logic             stall;

  assign full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign hs    = s_req_o & s_gnt_i;
  assign stall = s_req_o & ~s_gnt_i;
  assign head  = fifo_q[rd_ptr];
  assign pop   = s_rvalid_i & (count != '0);
  assign outstanding_o = count;

  // Winner: locked master, else first requester scanning upward from rr_ptr.
  always_comb begin
    logic             found;
    int unsigned      pos;
    logic [IDX_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    idx    = '0;
    if (lock_vld) begin
      winner = lock_idx;
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        pos = 32'(rr_ptr) + i;
        if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
        idx = IDX_W'(pos);
        if (!found && m_req_i[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end
  end

  // Slave request, payload mux, grant and response steering.
  always_comb begin
    s_req_o    = ((|m_req_i) | lock_vld) & ~full;
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = pop ? s_rdata_i : '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (s_req_o && winner == IDX_W'(k)) begin
        s_addr_o   = m_addr_i[k*ADDR_W +: ADDR_W];
        s_we_o     = m_we_i[k];
        s_be_o     = m_be_i[k*BE_W +: BE_W];
        s_wdata_o  = m_wdata_i[k*DATA_W +: DATA_W];
        m_gnt_o[k] = s_gnt_i;
      end
      if (pop && head == IDX_W'(k)) m_rvalid_o[k] = 1'b1;
    end
  end

  // Round-robin pointer and stall lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (hs) begin
      rr_ptr   <= (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + IDX_W'(1);
      lock_vld <= 1'b0;
    end else if (stall) begin
      lock_vld <= 1'b1;
      lock_idx <= winner;
    end
  end

  // Response-routing FIFO of granted master indices.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (hs) begin
        fifo_q[wr_ptr] <= winner;
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (hs && !pop)      count <= count + CNT_W'(1);
      else if (pop && !hs) count <= count - CNT_W'(1);
    end
  end

  // Sticky error: response with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        err_o <= 1'b0;
    else if (s_rvalid_i && count == '0) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_cpu64_obi_arbiter.sv
// Directed bench for cpu64_obi_arbiter (2 masters, depth 4).
module tb_cpu64_obi_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 39;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = DW / 8;

  logic            clk_i;
  logic            rst_ni;
  logic [NM-1:0]   m_req_i;
  logic [NM-1:0]   m_gnt_o;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM-1:0]   m_we_i;
  logic [NM*BW-1:0] m_be_i;
  logic [NM*DW-1:0] m_wdata_i;
  logic [NM-1:0]   m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            s_req_o;
  logic            s_gnt_i;
  logic [AW-1:0]   s_addr_o;
  logic            s_we_o;
  logic [BW-1:0]   s_be_o;
  logic [DW-1:0]   s_wdata_o;
  logic            s_rvalid_i;
  logic [DW-1:0]   s_rdata_i;
  logic [2:0]      outstanding_o;
  logic            err_o;

  int n_tests = 0;
  int n_fail  = 0;

  cpu64_obi_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge (inputs driven there, outputs sampled #1 later).
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni    = 1'b0;
    m_addr_i  = '0;
    m_we_i    = 2'b10;
    m_be_i    = {8'hF0, 8'h0F};
    m_wdata_i = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    idle_inputs();
    @(negedge clk_i);
    #1;
    check("rst_gnt", 64'(m_gnt_o), 64'h0);
    check("rst_sreq", 64'(s_req_o), 64'h0);
    check("rst_outst", 64'(outstanding_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_addr", 64'(s_addr_o), 64'h0);
    check("rst_rvalid", 64'(m_rvalid_o), 64'h0);
    rst_ni = 1'b1;

    // 1: single read from master 0
    step();
    m_addr_i[0 +: AW] = 39'h1000;
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    #1;
    check("t1_gnt", 64'(m_gnt_o), 64'h1);
    check("t1_addr", 64'(s_addr_o), 64'h1000);
    check("t1_we", 64'(s_we_o), 64'h0);
    check("t1_be", 64'(s_be_o), 64'h0F);
    step();
    m_req_i = 2'b00;
    s_gnt_i = 1'b0;
    #1;
    check("t1_gnt_off", 64'(m_gnt_o), 64'h0);
    check("t1_outst1", 64'(outstanding_o), 64'h1);
    step();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    check("t1_rvalid", 64'(m_rvalid_o), 64'h1);
    check("t1_rdata", m_rdata_o, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    idle_inputs();
    #1;
    check("t1_outst0", 64'(outstanding_o), 64'h0);
    check("t1_err", 64'(err_o), 64'h0);

    // 2: two continuous requesters alternate; responses follow grant order
    do_reset();
    m_addr_i[0 +: AW]  = 39'h100;
    m_addr_i[AW +: AW] = 39'h200;
    m_req_i = 2'b11;
    s_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_gnt", 64'(m_gnt_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      check("t2_addr", 64'(s_addr_o), (i % 2 == 0) ? 64'h100 : 64'h200);
      step();
    end
    idle_inputs();
    #1;
    check("t2_outst4", 64'(outstanding_o), 64'h4);
    for (int i = 0; i < 4; i++) begin
      s_rvalid_i = 1'b1;
      s_rdata_i  = 64'(i + 10);
      #1;
      check("t2_rvalid", 64'(m_rvalid_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      check("t2_rdata", m_rdata_o, 64'(i + 10));
      step();
    end
    idle_inputs();
    #1;
    check("t2_drained", 64'(outstanding_o), 64'h0);

    // 3: stalled master 1 keeps the slave payload although master 0 has priority
    do_reset();
    m_addr_i[0 +: AW]  = 39'h3000;
    m_addr_i[AW +: AW] = 39'h2000;
    m_req_i = 2'b10;
    #1;
    check("t3_sreq", 64'(s_req_o), 64'h1);
    check("t3_addr_c1", 64'(s_addr_o), 64'h2000);
    step();
    m_req_i = 2'b11;
    #1;
    check("t3_addr_c2", 64'(s_addr_o), 64'h2000);
    check("t3_we_c2", 64'(s_we_o), 64'h1);
    check("t3_gnt_c2", 64'(m_gnt_o), 64'h0);
    step();
    #1;
    check("t3_addr_c3", 64'(s_addr_o), 64'h2000);
    step();
    s_gnt_i = 1'b1;
    #1;
    check("t3_gnt_m1", 64'(m_gnt_o), 64'h2);
    check("t3_addr_hs", 64'(s_addr_o), 64'h2000);
    step();
    #1;
    check("t3_gnt_m0", 64'(m_gnt_o), 64'h1);
    check("t3_addr_m0", 64'(s_addr_o), 64'h3000);
    step();
    idle_inputs();
    #1;
    check("t3_outst", 64'(outstanding_o), 64'h2);

    // 4: FIFO full blocks the request; a pop frees a slot only the next cycle
    do_reset();
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    repeat (4) step();
    #1;
    check("t4_full_sreq", 64'(s_req_o), 64'h0);
    check("t4_full_gnt", 64'(m_gnt_o), 64'h0);
    check("t4_outst4", 64'(outstanding_o), 64'h4);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 64'hABCD;
    #1;
    check("t4_pop_rvalid", 64'(m_rvalid_o), 64'h1);
    check("t4_no_bypass", 64'(s_req_o), 64'h0);
    step();
    s_rvalid_i = 1'b0;
    #1;
    check("t4_sreq_back", 64'(s_req_o), 64'h1);
    check("t4_outst3", 64'(outstanding_o), 64'h3);
    check("t4_gnt_back", 64'(m_gnt_o), 64'h1);
    step();
    idle_inputs();

    // 5: response with nothing outstanding sets a sticky error
    do_reset();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 64'h55;
    #1;
    check("t5_no_rvalid", 64'(m_rvalid_o), 64'h0);
    step();
    s_rvalid_i = 1'b0;
    #1;
    check("t5_err_set", 64'(err_o), 64'h1);
    repeat (3) step();
    #1;
    check("t5_err_held", 64'(err_o), 64'h1);
    do_reset();
    #1;
    check("t5_err_clr", 64'(err_o), 64'h0);

    // 6: reset mid-flight clears count, lock and round-robin pointer
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    repeat (2) step();
    m_req_i = 2'b10;
    s_gnt_i = 1'b0;
    step();
    #1;
    check("t6_pre_outst", 64'(outstanding_o), 64'h2);
    check("t6_pre_lock", 64'(s_addr_o), 64'h2000);
    m_req_i = 2'b00;
    rst_ni  = 1'b0;
    #1;
    check("t6_rst_outst", 64'(outstanding_o), 64'h0);
    check("t6_rst_sreq", 64'(s_req_o), 64'h0);
    step();
    rst_ni  = 1'b1;
    m_req_i = 2'b11;
    #1;
    check("t6_rr0_addr", 64'(s_addr_o), 64'h3000);
    s_gnt_i = 1'b1;
    #1;
    check("t6_rr0_gnt", 64'(m_gnt_o), 64'h1);
    step();
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
